// File: rtl/kalman_gain_unit_if.sv
// kalman_gain_unit_if
// Bundles every bus that the Kalman gain unit touches. It does not carry the
// scalar clock or reset.
//   Operand stream : p_in, r_in, in_valid -> / <- in_ready
//   Result stream  : k_out, k_valid, err_div0, err_timeout -> / <- k_ready
//   Status         : busy
//   Adder IP       : add_a/add_b operands out, add_res result in (tvalid only)
//   Divider IP     : div_a/div_b operands out, div_res result in (tvalid only)
// The slave modport is the gain unit's view. The master modport is the view of
// the surrounding system: the producer, the consumer and the two IPs.
interface kalman_gain_unit_if;
  logic [31:0] p_in;
  logic [31:0] r_in;
  logic        in_valid;
  logic        in_ready;

  logic [31:0] k_out;
  logic        k_valid;
  logic        k_ready;
  logic        err_div0;
  logic        err_timeout;
  logic        busy;

  logic [31:0] add_a_tdata;
  logic        add_a_tvalid;
  logic [31:0] add_b_tdata;
  logic        add_b_tvalid;
  logic [31:0] add_res_tdata;
  logic        add_res_tvalid;

  logic [31:0] div_a_tdata;
  logic        div_a_tvalid;
  logic [31:0] div_b_tdata;
  logic        div_b_tvalid;
  logic [31:0] div_res_tdata;
  logic        div_res_tvalid;

  modport slave (
    input  p_in, r_in, in_valid, k_ready,
    input  add_res_tdata, add_res_tvalid, div_res_tdata, div_res_tvalid,
    output in_ready, k_out, k_valid, err_div0, err_timeout, busy,
    output add_a_tdata, add_a_tvalid, add_b_tdata, add_b_tvalid,
    output div_a_tdata, div_a_tvalid, div_b_tdata, div_b_tvalid
  );

  modport master (
    output p_in, r_in, in_valid, k_ready,
    output add_res_tdata, add_res_tvalid, div_res_tdata, div_res_tvalid,
    input  in_ready, k_out, k_valid, err_div0, err_timeout, busy,
    input  add_a_tdata, add_a_tvalid, add_b_tdata, add_b_tvalid,
    input  div_a_tdata, div_a_tvalid, div_b_tdata, div_b_tvalid
  );
endinterface

// File: rtl/kalman_gain_unit.sv
// kalman_gain_unit
// Computes the scalar Kalman gain k = P / (P + R) in float32. It does this by
// sequencing one external adder IP and one external divider IP. Both IPs are
// tvalid-only streams with no backpressure.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : kalman_gain_unit_if.slave
//           - operand handshake: p_in/r_in/in_valid/in_ready
//           - result handshake: k_out/k_valid/k_ready
//           - flags: err_div0, err_timeout, busy
//           - adder and divider IP streams
// Only one transaction is in flight at a time. A P+R that is zero, denormal or
// negative short-circuits to k=0 with err_div0 set. An IP that stays silent for
// TIMEOUT_CYCLES wait cycles aborts the operation with k=0 and err_timeout set.
module kalman_gain_unit #(
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter logic [7:0]  ZERO_EXP_THRESH = 8'h00
) (
  input logic             clock,
  input logic             reset,
  kalman_gain_unit_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADD_ISSUE,
    ADD_WAIT,
    DIV_ISSUE,
    DIV_WAIT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      p_q, p_d;
  logic [31:0]      r_q, r_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      k_q, k_d;
  logic             err_div0_q, err_div0_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic add_issue;
  logic div_issue;
  logic sum_unusable;
  logic timeout_hit;

  // The denominator is judged on the incoming adder word. This lets the branch
  // to DONE or DIV_ISSUE happen in the same cycle that sum_q captures it.
  assign sum_unusable = (bus.add_res_tdata[30:23] <= ZERO_EXP_THRESH) ||
                        bus.add_res_tdata[31];
  assign timeout_hit  = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      p_q           <= '0;
      r_q           <= '0;
      sum_q         <= '0;
      k_q           <= '0;
      err_div0_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      r_q           <= r_d;
      sum_q         <= sum_d;
      k_q           <= k_d;
      err_div0_q    <= err_div0_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // k_q and the error flags change only when an input is accepted or when
  // DONE is entered. They therefore stay valid for the consumer after the
  // handshake completes.
  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    r_d           = r_q;
    sum_d         = sum_q;
    k_d           = k_q;
    err_div0_d    = err_div0_q;
    err_timeout_d = err_timeout_q;
    cnt_d         = cnt_q;
    add_issue     = 1'b0;
    div_issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          p_d           = bus.p_in;
          r_d           = bus.r_in;
          err_div0_d    = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = ADD_ISSUE;
        end
      end

      ADD_ISSUE: begin
        add_issue = 1'b1;
        cnt_d     = '0;
        state_d   = ADD_WAIT;
      end

      ADD_WAIT: begin
        if (bus.add_res_tvalid) begin
          sum_d = bus.add_res_tdata;
          if (sum_unusable) begin
            k_d        = '0;
            err_div0_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = DIV_ISSUE;
          end
        end else if (timeout_hit) begin
          k_d           = '0;
          err_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DIV_ISSUE: begin
        div_issue = 1'b1;
        cnt_d     = '0;
        state_d   = DIV_WAIT;
      end

      DIV_WAIT: begin
        if (bus.div_res_tvalid) begin
          k_d     = bus.div_res_tdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          k_d           = '0;
          err_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (bus.k_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.k_valid      = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.k_out        = k_q;
  assign bus.err_div0     = err_div0_q;
  assign bus.err_timeout  = err_timeout_q;

  assign bus.add_a_tdata  = p_q;
  assign bus.add_b_tdata  = r_q;
  assign bus.add_a_tvalid = add_issue;
  assign bus.add_b_tvalid = add_issue;

  assign bus.div_a_tdata  = p_q;
  assign bus.div_b_tdata  = sum_q;
  assign bus.div_a_tvalid = div_issue;
  assign bus.div_b_tvalid = div_issue;

endmodule

// File: tb/tb_kalman_gain_unit.sv
// tb_kalman_gain_unit
// Directed bench for kalman_gain_unit. The adder and divider IPs are behavioural
// stubs with a programmable latency. They answer from a small table of known
// float32 results. Each expected gain is pushed to a scoreboard when its
// operands are driven, and popped when k_valid appears.
module tb_kalman_gain_unit;

  localparam int unsigned TIMEOUT = 64;
  localparam int          ADD_LAT = 3;
  localparam int          BUDGET  = 400;

  logic clock = 1'b0;
  logic reset;

  kalman_gain_unit_if bus ();

  kalman_gain_unit #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .ZERO_EXP_THRESH(8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] k;
    logic        div0;
    logic        tout;
    bit          ulp;
  } exp_t;

  exp_t sb_q[$];

  // Known float32 results returned by the IP stubs. Any other operand pair
  // returns a quiet NaN.
  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3e99999a, 32'h3e99999a}: return 32'h3f19999a;
      {32'h3f800000, 32'h00000000}: return 32'h3f800000;
      {32'h3e99999a, 32'h3dcccccd}: return 32'h3ecccccd;
      {32'h00000000, 32'h00000000}: return 32'h00000000;
      {32'hbf800000, 32'h00000000}: return 32'hbf800000;
      {32'h00000001, 32'h00000000}: return 32'h00000001;
      {32'h00800000, 32'h00000000}: return 32'h00800000;
      default:                      return 32'h7fc00000;
    endcase
  endfunction

  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3e99999a, 32'h3f19999a}: return 32'h3f000000;
      {32'h3f800000, 32'h3f800000}: return 32'h3f800000;
      {32'h3e99999a, 32'h3ecccccd}: return 32'h3f400000;
      {32'h00800000, 32'h00800000}: return 32'h3f800000;
      default:                      return 32'h7fc00000;
    endcase
  endfunction

  int add_cnt    = 0;
  int div_cnt    = 0;
  int div_lat    = 5;
  bit div_stall  = 1'b0;
  int div_issues = 0;

  // Adder stub: the result appears ADD_LAT cycles after the issue cycle.
  always @(posedge clock) begin
    bus.add_res_tvalid <= 1'b0;
    if (add_cnt > 0) begin
      add_cnt <= add_cnt - 1;
      if (add_cnt == 1) bus.add_res_tvalid <= 1'b1;
    end
    if (bus.add_a_tvalid && bus.add_b_tvalid) begin
      add_cnt           <= ADD_LAT;
      bus.add_res_tdata <= add_model(bus.add_a_tdata, bus.add_b_tdata);
    end
  end

  // Divider stub: its latency is programmable. When stalled, it swallows the request.
  always @(posedge clock) begin
    bus.div_res_tvalid <= 1'b0;
    if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) bus.div_res_tvalid <= 1'b1;
    end
    if (bus.div_a_tvalid && bus.div_b_tvalid) begin
      div_issues <= div_issues + 1;
      if (!div_stall) begin
        div_cnt           <= div_lat;
        bus.div_res_tdata <= div_model(bus.div_a_tdata, bus.div_b_tdata);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " k_out"},       bus.k_out,       32'h0);
    check({tag, " k_valid"},     bus.k_valid,     32'h0);
    check({tag, " in_ready"},    bus.in_ready,    32'h1);
    check({tag, " err_div0"},    bus.err_div0,    32'h0);
    check({tag, " err_timeout"}, bus.err_timeout, 32'h0);
    check({tag, " busy"},        bus.busy,        32'h0);
  endtask

  // Called on a negedge. Pushes the expectation, holds in_valid until the
  // upcoming posedge accepts the operands, then returns on the next negedge.
  task automatic apply_stimulus(input logic [31:0] p, input logic [31:0] r,
                                input logic [31:0] k, input logic div0,
                                input logic tout, input bit ulp);
    exp_t e;
    int   n;
    e.k = k; e.div0 = div0; e.tout = tout; e.ulp = ulp;
    sb_q.push_back(e);
    bus.p_in     = p;
    bus.r_in     = r;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("in_ready before accept", bus.in_ready, 32'h1);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for k_valid, then pops the scoreboard and compares.
  task automatic check_output(input string tag);
    exp_t        e;
    logic [31:0] diff;
    int          n;
    n = 0;
    while (!bus.k_valid && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check({tag, " k_valid"}, bus.k_valid, 32'h1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      if (e.ulp) begin
        diff = (bus.k_out >= e.k) ? (bus.k_out - e.k) : (e.k - bus.k_out);
        checks++;
        assert (diff <= 32'd1) else begin
          errors++;
          $error("[TB] FAIL %s k_out: observed %h expected %h within 1 ulp", tag, bus.k_out, e.k);
        end
      end else begin
        check({tag, " k_out"}, bus.k_out, e.k);
      end
      check({tag, " err_div0"},    bus.err_div0,    {31'h0, e.div0});
      check({tag, " err_timeout"}, bus.err_timeout, {31'h0, e.tout});
      check({tag, " in_ready in DONE"}, bus.in_ready, 32'h0);
    end
  endtask

  task automatic finish_transfer(input string tag);
    bus.k_ready = 1'b1;
    @(negedge clock);
    check({tag, " k_valid dropped"}, bus.k_valid,  32'h0);
    check({tag, " in_ready back"},   bus.in_ready, 32'h1);
    check({tag, " busy idle"},       bus.busy,     32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    int  gap;
    int  kv_seen;
    int  issues_before;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.p_in     = '0;
    bus.r_in     = '0;
    bus.k_ready  = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clock);

    // Equal P and R give 0.5.
    apply_stimulus(32'h3e99999a, 32'h3e99999a, 32'h3f000000, 1'b0, 1'b0, 1'b0);
    check("busy after accept", bus.busy, 32'h1);
    check("in_ready after accept", bus.in_ready, 32'h0);
    check_output("equal");
    finish_transfer("equal");

    // Zero noise gives a gain of 1.0. Then 0.3/(0.3+0.1) gives 0.75 within 1 ulp.
    apply_stimulus(32'h3f800000, 32'h00000000, 32'h3f800000, 1'b0, 1'b0, 1'b0);
    check_output("zero noise");
    finish_transfer("zero noise");
    apply_stimulus(32'h3e99999a, 32'h3dcccccd, 32'h3f400000, 1'b0, 1'b0, 1'b1);
    check_output("0.75");
    finish_transfer("0.75");

    // A zero sum must bypass the divider entirely.
    issues_before = div_issues;
    apply_stimulus(32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    check_output("zero sum");
    check("zero sum divider issues", div_issues - issues_before, 32'h0);
    finish_transfer("zero sum");
    check("err_div0 persists", bus.err_div0, 32'h1);

    // The next accepted input clears the flag. k_out holds until DONE.
    apply_stimulus(32'h3e99999a, 32'h3e99999a, 32'h3f000000, 1'b0, 1'b0, 1'b0);
    check("err_div0 cleared on accept", bus.err_div0, 32'h0);
    check("k_out held until DONE", bus.k_out, 32'h0);
    check_output("after zero sum");
    finish_transfer("after zero sum");

    // Negative variance and a denormal sum both count as division by zero.
    // The smallest normal sum does not.
    apply_stimulus(32'hbf800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    check_output("negative sum");
    finish_transfer("negative sum");
    apply_stimulus(32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    check_output("denormal sum");
    finish_transfer("denormal sum");
    apply_stimulus(32'h00800000, 32'h00000000, 32'h3f800000, 1'b0, 1'b0, 1'b0);
    check_output("min normal sum");
    finish_transfer("min normal sum");

    // Backpressure: hold DONE for 20 cycles while in_valid pulses are offered.
    bus.k_ready = 1'b0;
    apply_stimulus(32'h3f800000, 32'h00000000, 32'h3f800000, 1'b0, 1'b0, 1'b0);
    check_output("backpressure");
    bus.p_in = 32'h0;
    bus.r_in = 32'h0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      @(negedge clock);
      check("bp k_valid", bus.k_valid, 32'h1);
      check("bp k_out", bus.k_out, 32'h3f800000);
      check("bp in_ready", bus.in_ready, 32'h0);
    end
    bus.in_valid = 1'b0;
    finish_transfer("backpressure");
    kv_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.k_valid) kv_seen++;
    end
    check("bp single transfer", kv_seen, 32'h0);

    // Divider timeout: count the wait cycles between DIV_ISSUE and k_valid.
    div_stall = 1'b1;
    apply_stimulus(32'h3e99999a, 32'h3e99999a, 32'h00000000, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!bus.div_a_tvalid && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("timeout div issued", bus.div_a_tvalid, 32'h1);
    gap = 0;
    @(negedge clock);
    while (!bus.k_valid && gap < BUDGET) begin
      gap++;
      @(negedge clock);
    end
    check("timeout wait cycles", gap, TIMEOUT);
    check_output("timeout");
    finish_transfer("timeout");
    div_stall = 1'b0;

    // Reset in DIV_WAIT. The divider answers late, after reset is released.
    div_lat = 12;
    apply_stimulus(32'h3e99999a, 32'h3e99999a, 32'h3f000000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.div_a_tvalid && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge clock);
    check_reset_values("mid reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("after release");
    kv_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.k_valid) kv_seen++;
    end
    check("late divider ignored", kv_seen, 32'h0);
    div_lat = 5;
    apply_stimulus(32'h3e99999a, 32'h3e99999a, 32'h3f000000, 1'b0, 1'b0, 1'b0);
    check_output("post reset");
    finish_transfer("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
